// File: rtl/video_capture.sv
// Receive side of the PET video interface: samples serial video and its syncs and
// writes the picture into a frame buffer as a row-major, MSB-first bitmap.
module video_capture #(
    parameter int H_SKIP  = 8,
    parameter int H_BYTES = 40,
    parameter int V_SKIP  = 4,
    parameter int V_LINES = 200,
    parameter int ADDR_W  = 14
) (
    input  logic              clk16_i,
    input  logic              reset_ni,
    input  logic              pixel_en_i,
    input  logic              h_sync_i,
    input  logic              v_sync_i,
    input  logic              video_i,
    input  logic              enable_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [7:0]        wr_data_o,
    output logic              frame_done_o,
    output logic              sync_err_o
);

    localparam int SKIP_MAX = (H_SKIP > V_SKIP) ? H_SKIP : V_SKIP;
    localparam int SKIP_W   = (SKIP_MAX < 1) ? 1 : $clog2(SKIP_MAX + 1);
    localparam int BYTE_W   = $clog2(H_BYTES + 1);
    localparam int LINE_W   = $clog2(V_LINES + 1);

    if (H_BYTES < 1 || V_LINES < 1 || H_BYTES * V_LINES > (1 << ADDR_W)) begin : g_bad_geometry
        $error("video_capture: H_BYTES*V_LINES must be non-zero and fit in ADDR_W bits");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_V_SKIP,
        ST_H_WAIT,
        ST_H_SKIP,
        ST_CAPTURE
    } state_t;

    localparam state_t FRAME_ST = (V_SKIP == 0) ? ST_H_WAIT  : ST_V_SKIP;
    localparam state_t LINE_ST  = (H_SKIP == 0) ? ST_CAPTURE : ST_H_SKIP;

    state_t state, state_nxt;

    logic [1:0]        h_ff, v_ff, vid_ff;
    logic              h_prev, v_prev;
    logic              h_edge, v_edge, vid_s;

    logic [SKIP_W-1:0] skip_cnt;
    logic [2:0]        bit_cnt;
    logic [BYTE_W-1:0] byte_idx;
    logic [LINE_W-1:0] line;
    logic [ADDR_W-1:0] addr, line_base, next_base;
    logic [7:0]        shift_q, byte_nxt;

    logic start_frame, in_line, h_abort, line_start, vskip_edge;
    logic skip_px, cap_px, byte_done, line_done, last_line, sync_err_set;

    // All three inputs share one 2-FF depth so video stays aligned with its syncs.
    always_ff @(posedge clk16_i or negedge reset_ni) begin
        if (!reset_ni) begin
            // NOTE: synchronizers reset to 0 so a high sync after reset reads as a rising
            // edge, which is ignored, instead of a spurious falling edge.
            h_ff   <= '0;
            v_ff   <= '0;
            vid_ff <= '0;
            h_prev <= 1'b0;
            v_prev <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make each stage load the previous stage's old
            // value, which is what turns these lines into a real two-stage chain.
            h_ff   <= {h_ff[0], h_sync_i};
            v_ff   <= {v_ff[0], v_sync_i};
            vid_ff <= {vid_ff[0], video_i};
            h_prev <= h_ff[1];
            v_prev <= v_ff[1];
        end
    end

    assign h_edge    = h_prev & ~h_ff[1];
    assign v_edge    = v_prev & ~v_ff[1];
    assign vid_s     = vid_ff[1];
    assign byte_nxt  = {shift_q[6:0], vid_s};
    assign next_base = line_base + ADDR_W'(H_BYTES);

    always_ff @(posedge clk16_i or negedge reset_ni) begin
        if (!reset_ni) state <= ST_IDLE;
        else           state <= state_nxt;
    end

    // V edges win over H edges; strobes landing on an edge cycle belong to no line.
    always_comb begin
        start_frame  = enable_i & v_edge;
        in_line      = (state == ST_H_SKIP) || (state == ST_CAPTURE);
        h_abort      = enable_i & ~v_edge & h_edge & in_line;
        line_start   = enable_i & ~v_edge & h_edge & (in_line || state == ST_H_WAIT);
        vskip_edge   = enable_i & ~v_edge & h_edge & (state == ST_V_SKIP);
        skip_px      = enable_i & ~v_edge & ~h_edge & pixel_en_i & (state == ST_H_SKIP);
        cap_px       = enable_i & ~v_edge & ~h_edge & pixel_en_i & (state == ST_CAPTURE);
        byte_done    = cap_px & (bit_cnt == 3'd7);
        line_done    = byte_done & (int'(byte_idx) == H_BYTES - 1);
        last_line    = (int'(line) == V_LINES - 1);
        sync_err_set = (start_frame & ~(state == ST_IDLE || state == ST_V_SKIP)) | h_abort;
    end

    always_comb begin
        // NOTE: default first, so every path drives state_nxt and no latch is inferred.
        state_nxt = state;
        if (!enable_i) begin
            state_nxt = ST_IDLE;
        end else if (start_frame) begin
            state_nxt = FRAME_ST;
        end else begin
            case (state)
                ST_V_SKIP: begin
                    if (vskip_edge && int'(skip_cnt) == V_SKIP - 1) state_nxt = ST_H_WAIT;
                end
                ST_H_WAIT: begin
                    if (line_start) state_nxt = LINE_ST;
                end
                ST_H_SKIP, ST_CAPTURE: begin
                    if (h_abort)
                        state_nxt = last_line ? ST_IDLE : LINE_ST;
                    else if (skip_px && int'(skip_cnt) == H_SKIP - 1)
                        state_nxt = ST_CAPTURE;
                    else if (line_done)
                        state_nxt = last_line ? ST_IDLE : ST_H_WAIT;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk16_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_en_o      <= 1'b0;
            wr_addr_o    <= '0;
            wr_data_o    <= '0;
            frame_done_o <= 1'b0;
            sync_err_o   <= 1'b0;
            skip_cnt     <= '0;
            bit_cnt      <= '0;
            byte_idx     <= '0;
            line         <= '0;
            addr         <= '0;
            line_base    <= '0;
            shift_q      <= '0;
        end else begin
            wr_en_o      <= 1'b0;
            frame_done_o <= 1'b0;
            if (!enable_i) begin
                sync_err_o <= 1'b0;
            end else begin
                if (sync_err_set) sync_err_o <= 1'b1;
                if (start_frame) begin
                    skip_cnt  <= '0;
                    line      <= '0;
                    line_base <= '0;
                    addr      <= '0;
                end else if (vskip_edge) begin
                    skip_cnt <= skip_cnt + 1'b1;
                end else if (line_start) begin
                    skip_cnt <= '0;
                    bit_cnt  <= '0;
                    byte_idx <= '0;
                    // An aborted line still consumes its full slot in the bitmap.
                    if (h_abort) begin
                        line      <= line + 1'b1;
                        line_base <= next_base;
                        addr      <= next_base;
                    end
                end else if (skip_px) begin
                    skip_cnt <= skip_cnt + 1'b1;
                end else if (cap_px) begin
                    shift_q <= byte_nxt;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (byte_done) begin
                        wr_en_o      <= 1'b1;
                        wr_data_o    <= byte_nxt;
                        wr_addr_o    <= addr;
                        frame_done_o <= line_done & last_line;
                        addr         <= addr + 1'b1;
                        byte_idx     <= byte_idx + 1'b1;
                        if (line_done) begin
                            line      <= line + 1'b1;
                            line_base <= next_base;
                        end
                    end
                end
            end
        end
    end

endmodule
